// File: rtl/button_pkg.sv
// button_pkg
//   Shared types and defaults for the button conditioner.
//   rep_state_t : per-channel auto-repeat FSM state
//   DEF_*       : default parameter values for the conditioner and its channels
//   cnt_width() : bits needed to hold the values 0..max_val (minimum 1)
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int DEF_N_BTN          = 8;
  localparam int DEF_SAMPLE_DIV     = 5000;
  localparam int DEF_STABLE_SAMPLES = 31;
  localparam int DEF_REPEAT_DELAY   = 500;
  localparam int DEF_REPEAT_RATE    = 100;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// btn_channel
//   One button channel: 2-flop synchroniser, sample-tick integrator debouncer,
//   registered press/release strobes and an auto-repeat FSM.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     sample_tick  : shared 1-cycle debounce sample strobe
//     btn_raw      : asynchronous raw level
//     repeat_en    : auto-repeat enable, checked every clock
//     btn_level    : debounced level
//     btn_press    : 1-cycle strobe on debounced 0->1
//     btn_release  : 1-cycle strobe on debounced 1->0
//     btn_repeat   : 1-cycle auto-repeat strobe
//     btn_step     : btn_press | btn_repeat
//
//   Repeat FSM:
//     state  | meaning
//     IDLE   | no repeat activity
//     DELAY  | pressed with repeat enabled, counting ticks to the first repeat
//     REPEAT | counting ticks between subsequent repeats
module btn_channel
  import button_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat,
  output logic btn_step
);

  localparam int CNT_W = cnt_width(STABLE_SAMPLES);
  localparam int RC_W  = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  logic             sync_meta;
  logic             sync_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             flip;
  logic             press_d;
  logic             release_d;

  rep_state_t       state;
  rep_state_t       state_nxt;
  logic [RC_W-1:0]  rc;
  logic [RC_W-1:0]  rc_nxt;
  logic [RC_W-1:0]  rc_inc;
  logic             rep_exit;
  logic             delay_done;
  logic             rate_done;
  logic             repeat_d;

  // Level flips only when the sampled input has disagreed for STABLE_SAMPLES
  // consecutive ticks; press/release are derived from the same condition so
  // they land on the same edge as the level change.
  assign cnt_inc   = cnt + CNT_W'(1);
  assign flip      = sample_tick && (sync_s != btn_level) &&
                     (cnt_inc == CNT_W'(STABLE_SAMPLES));
  assign press_d   = flip & ~btn_level;
  assign release_d = flip & btn_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta   <= 1'b0;
      sync_s      <= 1'b0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_step    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_s    <= sync_meta;
      if (sample_tick) begin
        if (sync_s == btn_level) begin
          cnt <= '0;
        end else if (flip) begin
          cnt       <= '0;
          btn_level <= ~btn_level;
        end else begin
          cnt <= cnt_inc;
        end
      end
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_step    <= press_d | repeat_d;
    end
  end

  // Release and a dropped enable both abort repeating immediately; the
  // release uses the same-edge condition so no repeat can coincide with it.
  assign rc_inc     = rc + RC_W'(1);
  assign rep_exit   = release_d | ~repeat_en;
  assign delay_done = sample_tick && (state == DELAY)  && (rc_inc == RC_W'(REPEAT_DELAY));
  assign rate_done  = sample_tick && (state == REPEAT) && (rc_inc == RC_W'(REPEAT_RATE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rc         <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state      <= state_nxt;
      rc         <= rc_nxt;
      btn_repeat <= repeat_d;
    end
  end

  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    case (state)
      IDLE: begin
        if (press_d && repeat_en) begin
          state_nxt = DELAY;
          rc_nxt    = '0;
        end
      end
      DELAY: begin
        if (sample_tick) begin
          if (delay_done) begin
            state_nxt = REPEAT;
            rc_nxt    = '0;
          end else begin
            rc_nxt = rc_inc;
          end
        end
      end
      REPEAT: begin
        if (sample_tick) begin
          rc_nxt = rate_done ? '0 : rc_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        rc_nxt    = '0;
      end
    endcase
    if (rep_exit) begin
      state_nxt = IDLE;
      rc_nxt    = '0;
    end
  end

  always_comb begin
    repeat_d = (delay_done | rate_done) & ~rep_exit;
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Debounces N_BTN raw button/switch inputs against a shared sample tick and
//   produces clean levels plus press, release, auto-repeat and step strobes.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     btn_raw      : asynchronous raw levels, active-high
//     repeat_en    : per-channel auto-repeat enable
//     btn_level    : debounced levels
//     btn_press    : 1-cycle strobes on debounced 0->1
//     btn_release  : 1-cycle strobes on debounced 1->0
//     btn_repeat   : 1-cycle auto-repeat strobes while held
//     btn_step     : btn_press | btn_repeat
//     sample_tick  : 1-cycle strobe every SAMPLE_DIV clocks
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN          = DEF_N_BTN,
  parameter int SAMPLE_DIV     = DEF_SAMPLE_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_step,
  output logic             sample_tick
);

  localparam int DIV_W = cnt_width(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Gated by rst so the tick stays low in reset even when SAMPLE_DIV is 1.
  assign sample_tick = div_wrap & ~rst;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .btn_raw     (btn_raw[i]),
      .repeat_en   (repeat_en[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i]),
      .btn_step    (btn_step[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_step;
  logic         sample_tick;

  int checks = 0;
  int errors = 0;
  int cyc;

  int press_cnt[N];
  int rel_cnt[N];
  int rep_cnt[N];
  int press_cyc[N];
  int rel_cyc[N];
  int rep_q[$];

  button_conditioner #(
    .N_BTN          (N),
    .SAMPLE_DIV     (4),
    .STABLE_SAMPLES (3),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .btn_step    (btn_step),
    .sample_tick (sample_tick)
  );

  always #5 clk = ~clk;

  // Bench cycle count: number of posedges since the last reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_until(input int c);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != c && guard < 400);
    #2;
    check("run_until_cyc", cyc, c);
  endtask

  // Strobe recorder and per-cycle invariants, sampled just after each negedge.
  initial begin
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; rep_cnt[i] = 0;
      press_cyc[i] = -1; rel_cyc[i] = -1;
    end
  end

  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (btn_press[i] === 1'b1)   begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (btn_release[i] === 1'b1) begin rel_cnt[i]++;   rel_cyc[i] = cyc;   end
      if (btn_repeat[i] === 1'b1)  begin
        rep_cnt[i]++;
        if (i == 2) rep_q.push_back(cyc);
      end
    end
    if (btn_step !== (btn_press | btn_repeat))
      check("step_is_press_or_repeat", btn_step, btn_press | btn_repeat);
    if ((btn_press & btn_release) !== '0)
      check("press_release_exclusive", btn_press & btn_release, 0);
    if (!rst)
      check("sample_tick_grid", sample_tick, (cyc % 4 == 3) ? 1 : 0);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_level",   btn_level,   0);
    check("rst_press",   btn_press,   0);
    check("rst_release", btn_release, 0);
    check("rst_repeat",  btn_repeat,  0);
    check("rst_step",    btn_step,    0);
    check("rst_tick",    sample_tick, 0);
    rst = 1'b0;

    // Clean press on ch0: s rises at cycle 3, ticks at 4, 8, 12
    run_until(1);
    btn_raw[0] = 1'b1;
    run_until(11);
    check("press0_level_before", btn_level[0], 0);
    run_until(12);
    check("press0_level", btn_level[0], 1);
    check("press0_press", btn_press, 4'b0001);
    check("press0_step",  btn_step,  4'b0001);
    run_until(13);
    check("press0_press_1cyc", btn_press[0], 0);
    check("press0_step_1cyc",  btn_step[0],  0);
    check("press0_level_held", btn_level[0], 1);

    // Bounce on ch1: 2 ticks high, 1 low, 2 high, then low
    btn_raw[1] = 1'b1;
    run_until(21);
    btn_raw[1] = 1'b0;
    run_until(25);
    btn_raw[1] = 1'b1;
    run_until(33);
    btn_raw[1] = 1'b0;
    run_until(40);
    check("bounce1_level",   btn_level[1], 0);
    check("bounce1_press",   press_cnt[1], 0);
    check("bounce1_release", rel_cnt[1],   0);

    // Release ch0: s falls at 42, ticks 44, 48, 52
    btn_raw[0] = 1'b0;
    run_until(53);
    check("rel0_cnt",   rel_cnt[0], 1);
    check("rel0_cyc",   rel_cyc[0], 52);
    check("rel0_level", btn_level[0], 0);
    check("rep0_none",  rep_cnt[0], 0);

    // Simultaneous press on ch0 and ch3
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    run_until(64);
    check("simul_press", btn_press, 4'b1001);
    check("simul_step",  btn_step,  4'b1001);
    run_until(65);
    check("simul_press0_cyc", press_cyc[0], 64);
    check("simul_press3_cyc", press_cyc[3], 64);
    check("simul_press3_cnt", press_cnt[3], 1);
    check("simul_level", btn_level, 4'b1001);
    check("simul_press2_none", press_cnt[2], 0);
    btn_raw[0] = 1'b0;
    btn_raw[3] = 1'b0;
    run_until(77);
    check("simul_rel0_cyc", rel_cyc[0], 76);
    check("simul_rel3_cyc", rel_cyc[3], 76);
    check("simul_level_low", btn_level, 0);

    // Auto-repeat on ch2: press at 88, repeats at 108, 116, 124, 132
    repeat_en = 4'b0100;
    btn_raw[2] = 1'b1;
    run_until(89);
    check("rep2_press_cyc", press_cyc[2], 88);
    run_until(107);
    check("rep2_no_early_repeat", rep_q.size(), 0);
    run_until(108);
    check("rep2_first_repeat", btn_repeat, 4'b0100);
    check("rep2_first_step",   btn_step,   4'b0100);
    run_until(134);
    check("rep2_count_a", rep_q.size(), 4);
    check("rep2_q0", rep_q[0], 108);
    check("rep2_q1", rep_q[1], 116);
    check("rep2_q2", rep_q[2], 124);
    check("rep2_q3", rep_q[3], 132);

    // Drop repeat_en while in REPEAT, then re-raise while still held
    repeat_en[2] = 1'b0;
    run_until(150);
    check("rep2_after_drop", rep_q.size(), 4);
    repeat_en[2] = 1'b1;
    run_until(170);
    check("rep2_after_reraise", rep_q.size(), 4);
    check("rep2_level_held", btn_level[2], 1);
    btn_raw[2] = 1'b0;
    run_until(185);
    check("rep2_rel_cyc", rel_cyc[2], 184);
    check("rep2_count_b", rep_q.size(), 4);

    // Fresh press re-arms repeat: press at 196, repeats 216, 224, 232,
    // release at 236 (s falls at 227, ticks 228, 232, 236)
    btn_raw[2] = 1'b1;
    run_until(197);
    check("rep2_press2_cyc", press_cyc[2], 196);
    check("rep2_press2_cnt", press_cnt[2], 2);
    run_until(225);
    check("rep2_count_c", rep_q.size(), 6);
    check("rep2_q4", rep_q[4], 216);
    check("rep2_q5", rep_q[5], 224);
    btn_raw[2] = 1'b0;
    run_until(237);
    check("rep2_rel2_cyc", rel_cyc[2], 236);
    check("rep2_count_d", rep_q.size(), 7);
    check("rep2_q6", rep_q[6], 232);

    // Reset while ch0 is held
    btn_raw[0] = 1'b1;
    run_until(249);
    check("rst0_press_cyc", press_cyc[0], 248);
    check("rst0_press_cnt", press_cnt[0], 3);
    check("rst0_level", btn_level[0], 1);
    run_until(250);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("midrst_level",   btn_level,   0);
    check("midrst_press",   btn_press,   0);
    check("midrst_release", btn_release, 0);
    check("midrst_repeat",  btn_repeat,  0);
    check("midrst_step",    btn_step,    0);
    check("midrst_tick",    sample_tick, 0);
    check("midrst_no_rel",  rel_cnt[0],  2);
    rst = 1'b0;
    run_until(11);
    check("postrst_level_before", btn_level[0], 0);
    run_until(13);
    check("postrst_press_cyc", press_cyc[0], 12);
    check("postrst_press_cnt", press_cnt[0], 4);
    check("postrst_no_rel",    rel_cnt[0],   2);
    check("postrst_level",     btn_level[0], 1);
    check("no_repeat_ch0", rep_cnt[0], 0);
    check("no_repeat_ch1", rep_cnt[1], 0);
    check("no_repeat_ch3", rep_cnt[3], 0);
    check("rep2_total",    rep_cnt[2], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front end for the calculator's push-button and switch inputs: read, write, exec, dig1..dig4 and similar.
- Each raw input is synchronised to clk and debounced using a shared sample tick.
- Produces clean levels plus single-cycle press, release and auto-repeat strobes.
- Sits directly upstream of the calculator interface FSM, replacing its per-input shift-register debouncers. Digit-stepping then becomes a simple "on btn_step, increment".

Parameters:
- N_BTN, 8, number of independent button channels.
- SAMPLE_DIV, 5000, clk cycles per debounce sample tick (>=1).
- STABLE_SAMPLES, 31, consecutive differing samples required to flip a debounced level (>=1).
- REPEAT_DELAY, 500, sample ticks from press to first repeat strobe (>=1).
- REPEAT_RATE, 100, sample ticks between subsequent repeat strobes (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button/switch levels, active-high.
- repeat_en  in  N_BTN  per-channel auto-repeat enable.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  1-cycle strobe on debounced 0->1.
- btn_release  out  N_BTN  1-cycle strobe on debounced 1->0.
- btn_repeat  out  N_BTN  1-cycle auto-repeat strobe while held.
- btn_step  out  N_BTN  btn_press | btn_repeat (registered, same cycle as its sources).
- sample_tick  out  1  1-cycle strobe every SAMPLE_DIV clocks.

Behaviour:
- Reset state: all outputs 0; sync flops, divider, integrators and repeat counters 0; every repeat FSM in IDLE.
- Synchroniser: 2-flop per bit. Output s[i] lags btn_raw by 2 clk.
- Divider:
  - counter runs 0..SAMPLE_DIV-1 and wraps;
  - sample_tick=1 in the cycle the counter equals SAMPLE_DIV-1;
  - SAMPLE_DIV=1 gives a tick every cycle;
  - the first tick comes SAMPLE_DIV cycles after rst deasserts.
- Integrator (per channel, acts only on sample_tick):
  - if s[i]==btn_level[i], cnt clears to 0;
  - otherwise cnt increments; when the incremented value equals STABLE_SAMPLES, btn_level[i] toggles and cnt clears;
  - a glitch shorter than STABLE_SAMPLES samples never changes the level.
  - cnt width is clog2(STABLE_SAMPLES+1).
- Strobes:
  - btn_press/btn_release assert on the clock edge where btn_level toggles (registered), for exactly one cycle;
  - never both asserted in the same cycle on one channel.
- Repeat FSM (per channel): states IDLE, DELAY, REPEAT; rc counter advances on sample_tick only.
  - IDLE -> DELAY on btn_press, provided repeat_en[i]=1; rc=0.
  - DELAY: on each tick rc++. When rc reaches REPEAT_DELAY: btn_repeat=1 for that cycle, rc=0, go to REPEAT.
  - REPEAT: on each tick rc++. When rc reaches REPEAT_RATE: btn_repeat=1, rc=0.
  - Any state -> IDLE on btn_release, or on repeat_en[i]=0 (checked every clk). No strobe in the exit cycle.
  - repeat_en raised while already held does not start repeat; a new press is required.
- Channels are fully independent. Simultaneous presses on several channels all strobe in the same cycle.
- rst mid-hold:
  - everything clears and no release strobe is generated;
  - if the button is still held, btn_level rises again after STABLE_SAMPLES ticks with a fresh btn_press.
- Latency, raw edge to btn_press: 2 clk (sync) + wait to the next tick + (STABLE_SAMPLES-1) further ticks + 0 clk.

Decomposition:
- Shared package button_pkg:
  - rep_state_t enum (IDLE, DELAY, REPEAT);
  - default constants for SAMPLE_DIV, STABLE_SAMPLES, REPEAT_DELAY, REPEAT_RATE;
  - a clog2 helper if not already present.
- One sub-module btn_channel, generate-instantiated N_BTN times. It contains the synchroniser, integrator, strobe registers and repeat FSM.
- Top level contains only the divider and the instances.

Test Plan (bench params: SAMPLE_DIV=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_BTN=4):
- Clean press: btn_raw[0] 0->1 and held, repeat_en=0 -> btn_level[0] rises on the 3rd sample_tick after s[0]=1. btn_press[0] and btn_step[0] high for exactly 1 cycle. btn_repeat never asserts.
- Bounce rejection: btn_raw[1] high for 2 ticks, low 1 tick, high 2 ticks, then low -> btn_level[1] stays 0 and no strobes.
- Auto-repeat: repeat_en[2]=1, hold btn_raw[2] for 20 ticks -> press strobe, then btn_repeat[2] 5 ticks later, then every 2 ticks. Release stops repeats, and btn_release[2] fires 3 ticks after s[2]=0.
- Simultaneous: btn_raw[0] and btn_raw[3] rise in the same cycle -> btn_press[0] and btn_press[3] assert in the same cycle. Other channels stay 0.
- repeat_en drop: holding in REPEAT, set repeat_en[2]=0 -> no further btn_repeat. Re-raising it while still held -> still none until release and re-press.
- Reset mid-hold: assert rst 1 cycle while btn_level[0]=1 -> all outputs 0 the next cycle with no btn_release. Held button -> btn_press[0] again 3 ticks after the first post-reset tick.
